// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: state/owner encodings and default
// timing constants shared by the RAM port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_IF  = 2'd1,
    RD_MEM = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_t;

  localparam int DEF_MEM_LAT    = 2;
  localparam int DEF_STARVE_MAX = 3;
  localparam int LAT_W          = 3;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and RAM side
// signals of the shared memory port.
interface mem_port_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_rdata_valid;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_done;

  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  logic          stall_if;
  logic          stall_mem;

  modport master (
    output if_req, if_addr,
    output mem_req, mem_we,
    output mem_addr, mem_wdata,
    output ram_rdata,
    input  if_rdata, if_rdata_valid,
    input  mem_rdata, mem_done,
    input  ram_en, ram_we,
    input  ram_addr, ram_wdata,
    input  stall_if, stall_mem
  );

  modport slave (
    input  if_req, if_addr,
    input  mem_req, mem_we,
    input  mem_addr, mem_wdata,
    input  ram_rdata,
    output if_rdata, if_rdata_valid,
    output mem_rdata, mem_done,
    output ram_en, ram_we,
    output ram_addr, ram_wdata,
    output stall_if, stall_mem
  );

endinterface

// File: rtl/mem_port_arbiter_lat_counter.sv
// arb_lat_counter: loadable down-counter timing
// the RAM read latency; last flags count==1.
module arb_lat_counter
  import mem_arb_pkg::*;
#(
  parameter int W = LAT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && count != '0) begin
      count <= count - W'(1);
    end
  end

  assign last = (count == W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port RAM between fetch
// and data access. Optional macro: ARB_STARVE_GUARD_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int MEM_LAT    = DEF_MEM_LAT,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input logic              clk,
  input logic              reset,
  mem_port_arbiter_if.slave bus
);

  state_t           state;
  state_t           state_n;
  owner_t           owner;
  logic             run;
  logic             if_pend;
  logic             mem_pend;
  logic             force_if;
  logic             grant;
  logic             wr_done;
  logic             lat_load;
  logic             lat_en;
  logic             lat_last;
  logic [LAT_W-1:0] lat_cnt;
  logic             if_vld_q;
  logic             mem_done_q;
  logic [DW-1:0]    if_rdata_q;
  logic [DW-1:0]    mem_rdata_q;
  logic             mem_done_c;
  logic             ram_en_c;
  logic             ram_we_c;
  logic [AW-1:0]    ram_addr_c;
  logic [DW-1:0]    ram_wdata_c;

  assign run = reset;

  // a requester whose done pulse is up this cycle
  // is finished and must not be granted again
  assign if_pend  = bus.if_req & ~if_vld_q;
  assign mem_pend = bus.mem_req & ~mem_done_q;

  assign grant = run & (state == IDLE)
               & (if_pend | mem_pend);
  assign owner = (mem_pend & ~force_if)
               ? OWN_MEM : OWN_IF;

`ifdef ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_cnt;

  assign force_if = if_pend
    & (starve_cnt == SW'(STARVE_MAX));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (grant && owner == OWN_IF) begin
      starve_cnt <= '0;
    end else if (grant && if_pend
                 && starve_cnt != SW'(STARVE_MAX)) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end
`else
  logic unused_starve;
  assign force_if      = 1'b0;
  assign unused_starve = (STARVE_MAX > 0);
`endif

  assign lat_en = (state != IDLE);

  arb_lat_counter #(.W(LAT_W)) u_lat (
    .clk      (clk),
    .rst_n    (reset),
    .load     (lat_load),
    .load_val (LAT_W'(MEM_LAT)),
    .en       (lat_en),
    .count    (lat_cnt),
    .last     (lat_last)
  );

  always_comb begin
    state_n     = state;
    lat_load    = 1'b0;
    wr_done     = 1'b0;
    ram_en_c    = 1'b0;
    ram_we_c    = 1'b0;
    ram_addr_c  = '0;
    ram_wdata_c = '0;
    unique case (state)
      IDLE: begin
        if (grant) begin
          ram_en_c = 1'b1;
          unique case (1'b1)
            owner == OWN_MEM: begin
              ram_addr_c  = bus.mem_addr;
              ram_wdata_c = bus.mem_wdata;
              ram_we_c    = bus.mem_we;
              if (bus.mem_we) begin
                wr_done = 1'b1;
              end else begin
                state_n  = RD_MEM;
                lat_load = 1'b1;
              end
            end
            default: begin
              ram_addr_c = bus.if_addr;
              state_n    = RD_IF;
              lat_load   = 1'b1;
            end
          endcase
        end
      end
      RD_IF, RD_MEM: begin
        if (lat_last) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      if_vld_q    <= 1'b0;
      mem_done_q  <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state      <= state_n;
      if_vld_q   <= (state == RD_IF) & lat_last;
      mem_done_q <= (state == RD_MEM) & lat_last;
      if (state == RD_IF && lat_last)
        if_rdata_q <= bus.ram_rdata;
      if (state == RD_MEM && lat_last)
        mem_rdata_q <= bus.ram_rdata;
    end
  end

  assign mem_done_c = mem_done_q | wr_done;

  assign bus.ram_en         = ram_en_c;
  assign bus.ram_we         = ram_we_c;
  assign bus.ram_addr       = ram_addr_c;
  assign bus.ram_wdata      = ram_wdata_c;
  assign bus.if_rdata       = if_rdata_q;
  assign bus.if_rdata_valid = if_vld_q;
  assign bus.mem_rdata      = mem_rdata_q;
  assign bus.mem_done       = mem_done_c;

  // stalls are forced low while reset is held
  assign bus.stall_mem = run & bus.mem_req & ~mem_done_c;
  assign bus.stall_if  = run
    & ((bus.if_req & ~if_vld_q)
       | (bus.mem_req & ~mem_done_c));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random fetch/data traffic against a
// cycle-level arbitration model plus data scoreboards.
module tb_mem_port_arbiter;

  localparam int AW   = 8;
  localparam int DW   = 8;
  localparam int LAT  = 2;
  localparam int SMAX = 3;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(
    .AW(AW), .DW(DW),
    .MEM_LAT(LAT), .STARVE_MAX(SMAX)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  function automatic logic [7:0] init_val(input logic [7:0] a);
    return a ^ 8'h6C;
  endfunction

  function automatic void chk(input string nm,
                              input logic [63:0] act,
                              input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h cyc=%0d",
               nm, act, exp, cyc);
    end
  endfunction

  // RAM with a fixed read pipeline of LAT cycles
  logic [7:0] ram  [256];
  logic [7:0] pipe [LAT];
  initial for (int i = 0; i < 256; i++) ram[i] = init_val(8'(i));
  always @(posedge clk) begin
    if (bus.ram_en && bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
    pipe[0] <= (bus.ram_en && !bus.ram_we) ? ram[bus.ram_addr] : 8'hEE;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.ram_rdata = pipe[LAT-1];

  typedef struct packed {
    logic       we;
    logic [7:0] d;
  } mexp_t;

  logic [7:0] q_if[$];
  mexp_t      q_mem[$];
  logic [7:0] shadow [256];
  initial for (int i = 0; i < 256; i++) shadow[i] = init_val(8'(i));

  // cycle-level reference: who owns the port and when it frees
  int busy = 0;
  int done_at = 0;
  int starve = 0;
  logic e_ifv, e_mrd, e_mwr, e_md, ifp, mp, frc;
  logic e_en, e_we;
  logic [7:0] e_addr, e_wd;

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      busy = 0;
      starve = 0;
      chk("reset_outputs",
          {bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata,
           bus.if_rdata, bus.if_rdata_valid, bus.mem_rdata,
           bus.mem_done, bus.stall_if, bus.stall_mem}, 64'd0);
    end else begin
      e_ifv = (busy == 1 && cyc == done_at);
      e_mrd = (busy == 2 && cyc == done_at);
      if (e_ifv || e_mrd) busy = 0;
      ifp = bus.if_req && !e_ifv;
      mp  = bus.mem_req && !e_mrd;
      frc = GUARD && ifp && starve == SMAX;
      e_en = 0; e_we = 0; e_mwr = 0;
      e_addr = 0; e_wd = 0;
      if (busy == 0 && (ifp || mp)) begin
        e_en = 1;
        if (mp && !frc) begin
          e_addr = bus.mem_addr;
          e_we   = bus.mem_we;
          e_wd   = bus.mem_wdata;
          if (bus.mem_we) e_mwr = 1;
          else begin busy = 2; done_at = cyc + LAT + 1; end
          if (ifp && starve < SMAX) starve++;
        end else begin
          e_addr = bus.if_addr;
          busy = 1;
          done_at = cyc + LAT + 1;
          starve = 0;
        end
      end
      e_md = e_mrd || e_mwr;
      chk("cycle{en,we,ifv,mdone,stif,stmem}",
          {bus.ram_en, bus.ram_we, bus.if_rdata_valid,
           bus.mem_done, bus.stall_if, bus.stall_mem},
          {e_en, e_we, e_ifv, e_md,
           (bus.if_req && !e_ifv) || (bus.mem_req && !e_md),
           bus.mem_req && !e_md});
      if (e_en) chk("ram_addr", bus.ram_addr, e_addr);
      if (e_en && e_we) chk("ram_wdata", bus.ram_wdata, e_wd);
    end
  end

  // scoreboard: pop expected data whenever the DUT completes
  mexp_t me;
  always @(negedge clk) begin
    if (reset && bus.if_rdata_valid) begin
      if (q_if.size() == 0) begin
        checks++; errors++;
        $display("FAIL if_sb unexpected valid cyc=%0d", cyc);
      end else chk("if_rdata", bus.if_rdata, q_if.pop_front());
    end
    if (reset && bus.mem_done) begin
      if (q_mem.size() == 0) begin
        checks++; errors++;
        $display("FAIL mem_sb unexpected done cyc=%0d", cyc);
      end else begin
        me = q_mem.pop_front();
        if (!me.we) chk("mem_rdata", bus.mem_rdata, me.d);
      end
    end
  end

  task automatic do_fetch(input logic [7:0] a);
    int n;
    bus.if_addr = a;
    bus.if_req  = 1'b1;
    q_if.push_back(init_val(a));
    n = 0;
    do begin @(negedge clk); n++; end
    while (!bus.if_rdata_valid && n < 200);
    if (!bus.if_rdata_valid) begin
      checks++; errors++;
      $display("FAIL fetch_timeout got=none want=valid addr=%0h", a);
    end
    @(posedge clk); #1;
    bus.if_req = 1'b0;
  endtask

  task automatic do_mem(input logic we, input logic [7:0] a,
                        input logic [7:0] d);
    int n;
    bus.mem_we    = we;
    bus.mem_addr  = a;
    bus.mem_wdata = d;
    bus.mem_req   = 1'b1;
    if (we) begin
      shadow[a] = d;
      q_mem.push_back('{we: 1'b1, d: 8'h00});
    end else begin
      q_mem.push_back('{we: 1'b0, d: shadow[a]});
    end
    n = 0;
    do begin @(negedge clk); n++; end
    while (!bus.mem_done && n < 200);
    if (!bus.mem_done) begin
      checks++; errors++;
      $display("FAIL mem_timeout got=none want=done addr=%0h", a);
    end
    @(posedge clk); #1;
    bus.mem_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1);
  end

  initial begin
    int g;
    bus.if_req = 0; bus.if_addr = 0;
    bus.mem_req = 0; bus.mem_we = 0;
    bus.mem_addr = 0; bus.mem_wdata = 0;
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // reset in the middle of a data read discards it
    bus.mem_we = 0; bus.mem_addr = 8'h40; bus.mem_req = 1;
    @(posedge clk); #1;
    @(posedge clk); #2;
    reset = 1'b0;
    bus.mem_req = 0;
    #1;
    chk("async_reset_outputs",
        {bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata,
         bus.if_rdata, bus.if_rdata_valid, bus.mem_rdata,
         bus.mem_done, bus.stall_if, bus.stall_mem}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    do_fetch(8'h10);

    do_mem(1'b1, 8'h20, 8'hA5);

    fork
      do_mem(1'b0, 8'h30, 8'h00);
      do_fetch(8'h11);
    join

    fork
      do_fetch(8'h12);
      for (int i = 0; i < 4; i++)
        do_mem(1'b1, 8'h80 + 8'(i), 8'($urandom));
    join

    for (int i = 0; i < 8; i++) begin
      do_fetch(8'(i) + 8'h50);
      do_mem(1'b0, 8'h80 + 8'(i), 8'h00);
    end

    fork
      for (int i = 0; i < 40; i++) begin
        g = $urandom_range(0, 3);
        if (g > 0) begin repeat (g) @(posedge clk); #1; end
        do_fetch(8'($urandom_range(0, 127)));
      end
      for (int j = 0; j < 40; j++) begin
        int h;
        logic w;
        logic [7:0] a;
        h = $urandom_range(0, 3);
        if (h > 0) begin repeat (h) @(posedge clk); #1; end
        w = 1'($urandom_range(0, 1));
        a = 8'($urandom);
        if (w) a[7] = 1'b1;
        do_mem(w, a, 8'($urandom));
      end
    join

    repeat (6) @(negedge clk);
    chk("if_sb_drain", 64'(q_if.size()), 64'd0);
    chk("mem_sb_drain", 64'(q_mem.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous RAM between instruction fetch (IF stage) and the data access driven from the EX_MEM pipeline register outputs.
- Sequences each access: grant, fixed read latency, completion.
- Drives stall_if and stall_mem so the pipeline registers (IF_ID, ID_EX, EX_MEM) hold while their access is outstanding.

Parameters:
- AW, 8, address width.
- DW, 8, data width.
- MEM_LAT, 2, cycles from RAM read issue (ram_en=1, ram_we=0) to ram_rdata valid; legal range 1..7.
- STARVE_MAX, 3, consecutive data grants with a fetch pending before the fetch is forced (guard feature only).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request, held until if_rdata_valid
- if_addr  in  AW  fetch address
- if_rdata  out  DW  fetch data
- if_rdata_valid  out  1  one-cycle fetch completion pulse
- mem_req  in  1  data request from EX_MEM stage, held until mem_done
- mem_we  in  1  1=write, 0=read
- mem_addr  in  AW  data address (EX_MEM_alu_out)
- mem_wdata  in  DW  write data (EX_MEM_B)
- mem_rdata  out  DW  read data
- mem_done  out  1  one-cycle data completion pulse
- ram_en, ram_we  out  1 each  RAM strobes
- ram_addr  out  AW  RAM address
- ram_wdata  out  DW  RAM write data
- ram_rdata  in  DW  RAM read data
- stall_if  out  1  freeze PC and IF_ID
- stall_mem  out  1  freeze EX_MEM and all upstream registers

Behaviour:
- Reset: state=IDLE, lat_cnt=0, starve_cnt=0. All outputs 0, including if_rdata and mem_rdata. Reset asserted mid-access discards the access; no done pulse is produced.
- States:
  - IDLE: no access outstanding.
  - RD_IF: fetch read in flight.
  - RD_MEM: data read in flight.
- IDLE arbitration, evaluated each cycle:
  - Data has priority: mem_req=1 grants data, except under the guard rule.
  - Otherwise if_req=1 grants fetch.
  - Otherwise stay in IDLE.
- Grant cycle:
  - ram_en=1 for exactly one cycle. ram_addr, ram_wdata and ram_we are driven from the granted requester's inputs in that cycle.
- Data write:
  - ram_we=1; completes in the grant cycle.
  - mem_done=1 in the same cycle; state stays IDLE.
- Read:
  - On grant, load lat_cnt=MEM_LAT and go to RD_IF or RD_MEM.
  - Decrement lat_cnt each cycle.
  - When lat_cnt reaches 1: register ram_rdata into if_rdata or mem_rdata, pulse if_rdata_valid or mem_done next cycle, return to IDLE.
- Latency: read grant to valid/done = MEM_LAT+1 cycles.
- The next grant may occur in the cycle the done pulse is asserted (state is IDLE then). No ram_en is issued while in RD_*.
- Stall outputs (combinational):
  - stall_mem = mem_req & ~mem_done.
  - stall_if = (if_req & ~if_rdata_valid) | stall_mem.
- Requesters must hold req/addr/wdata stable until their done pulse. Dropping req mid-read is illegal; the read completes and the done pulse is ignored.
- if_rdata and mem_rdata hold their last value between accesses.
- Simultaneous mem_req and if_req in IDLE: data wins unless the guard forces fetch.

Optional Feature:
- Macro: ARB_STARVE_GUARD_EN.
- With macro:
  - starve_cnt increments on each data grant made while if_req=1, saturating at STARVE_MAX.
  - starve_cnt clears on any fetch grant.
  - In IDLE with starve_cnt==STARVE_MAX and if_req=1, fetch is granted even if mem_req=1.
- Without macro: strict data priority; starve_cnt is absent.

Decomposition:
- Package mem_arb_pkg holds:
  - state encoding (IDLE=2'd0, RD_IF=2'd1, RD_MEM=2'd2)
  - owner encoding (OWN_IF, OWN_MEM)
  - default MEM_LAT and STARVE_MAX constants
- One sub-module, arb_lat_counter: loadable down-counter with load, enable and last (count==1) flag, width 3. The FSM, muxing and stall logic stay in the top level.

Test Plan:
1. Reset low mid-RD_MEM (after 1 cycle) -> all outputs 0 immediately, no mem_done; after reset high with if_req=1, if_addr=8'h10 -> ram_en at next edge, if_rdata_valid 3 cycles later (MEM_LAT=2).
2. mem_req=1, mem_we=1, addr 8'h20, wdata 8'hA5 -> ram_en=ram_we=1, ram_addr=8'h20, ram_wdata=8'hA5, mem_done=1 same cycle; stall_mem=0 that cycle.
3. mem_req and if_req both high, data read 8'h30, RAM returns 8'h5C -> data granted first, stall_if=1 throughout; mem_rdata=8'h5C with mem_done at cycle 3; fetch granted in the done cycle.
4. Guard enabled, STARVE_MAX=3, if_req held, four back-to-back data writes -> first three granted to data; fourth cycle grants fetch while mem_req=1, stall_mem=1.
5. Guard disabled, same stimulus as 4 -> all four data writes granted before fetch; if_rdata_valid only after mem_req drops.
6. MEM_LAT=1 sweep of 16 alternating reads -> each done pulse 2 cycles after grant; at most one ram_en per access; never ram_en while in RD_*.
